// File: rtl/rect_fill_engine.sv
// rect_fill_engine: fills an inclusive rectangle, clipped to the screen, with
// one pixel write per cycle in raster order (left to right, top to bottom).
//
// Optional feature: define RECT_FILL_PATTERN_EN to add colour_b/pattern
// inputs. When pattern is latched high, pixels whose x/y parities differ
// take colour_b. This gives a checkerboard tied to absolute screen position.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   start                request a fill (accepted only when idle)
//   x0,y0,x1,y1          inclusive rectangle corners
//   colour_in            fill colour
//   colour_b, pattern    (RECT_FILL_PATTERN_EN only) second colour, checker enable
//   stall                downstream not accepting; hold the current pixel
//   x_out,y_out          current pixel coordinate
//   colour_out           current pixel colour
//   plot                 pixel write strobe
//   busy                 operation in progress
//   done                 one-cycle completion pulse
module rect_fill_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] colour_in,
`ifdef RECT_FILL_PATTERN_EN
    input  logic [COLOUR_W-1:0] colour_b,
    input  logic                pattern,
`endif
    input  logic                stall,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [COLOUR_W-1:0] colour_out,
    output logic                plot,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t              state;
    logic [X_W-1:0]      lx0, lx1, xe, cx;
    logic [Y_W-1:0]      ly0, ly1, ye, cy;
    logic [COLOUR_W-1:0] col;

    // Clip the latched corners; evaluated during SETUP only.
    logic [X_W-1:0] xe_c;
    logic [Y_W-1:0] ye_c;
    logic           empty_c;

    always_comb begin
        xe_c    = (lx1 > X_MAX) ? X_MAX : lx1;
        ye_c    = (ly1 > Y_MAX) ? Y_MAX : ly1;
        // Off-screen origins are tested at 32 bits so a screen size equal to
        // 2**X_W or 2**Y_W still works.
        empty_c = (lx0 > xe_c) || (ly0 > ye_c) ||
                  (32'(lx0) >= 32'(SCREEN_W)) || (32'(ly0) >= 32'(SCREEN_H));
    end

`ifdef RECT_FILL_PATTERN_EN
    logic [COLOUR_W-1:0] colb;
    logic                pat;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            lx0   <= '0;
            lx1   <= '0;
            ly0   <= '0;
            ly1   <= '0;
            xe    <= '0;
            ye    <= '0;
            cx    <= '0;
            cy    <= '0;
            col   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef RECT_FILL_PATTERN_EN
            colb  <= '0;
            pat   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        lx0   <= x0;
                        ly0   <= y0;
                        lx1   <= x1;
                        ly1   <= y1;
                        col   <= colour_in;
`ifdef RECT_FILL_PATTERN_EN
                        colb  <= colour_b;
                        pat   <= pattern;
`endif
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    xe <= xe_c;
                    ye <= ye_c;
                    if (empty_c) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cx    <= lx0;
                        cy    <= ly0;
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (!stall) begin
                        if (cx == xe && cy == ye) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (cx == xe) begin
                            cx <= lx0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobe is combinational so a stall suppresses the write in the same cycle.
    assign plot  = (state == FILL) && !stall;
    assign x_out = cx;
    assign y_out = cy;

`ifdef RECT_FILL_PATTERN_EN
    assign colour_out = (pat && (cx[0] ^ cy[0])) ? colb : col;
`else
    assign colour_out = col;
`endif

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] colour_in = '0;
    logic [2:0] colour_b = '0;
    logic       pattern = 1'b0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot, busy, done;

    rect_fill_engine dut (
        .clk(clk), .reset(rst), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
`ifdef RECT_FILL_PATTERN_EN
        .colour_b(colour_b), .pattern(pattern),
`endif
        .stall(stall), .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    pix_t exp_q[$];

    int checks = 0, errors = 0;
    int cyc = 0, accept_cyc = 0, last_plot_cyc = 0, done_cnt = 0, exp_npix = 0;
    bit stall_en = 1'b0, lat_chk = 1'b0, first_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: every on-screen pixel of the rectangle, raster order.
    task automatic push_expect(input int ax0, input int ay0, input int ax1, input int ay1,
                               input int col, input int colb, input int pat, output int n);
        int xe, ye;
        pix_t p;
        xe = (ax1 > 159) ? 159 : ax1;
        ye = (ay1 > 119) ? 119 : ay1;
        n = 0;
        for (int y = ay0; y <= ye; y++)
            for (int x = ax0; x <= xe; x++) begin
                p.x = x;
                p.y = y;
                p.c = col;
`ifdef RECT_FILL_PATTERN_EN
                if (pat != 0 && ((x ^ y) & 1) != 0) p.c = colb;
`endif
                exp_q.push_back(p);
                n++;
            end
    endtask

    // Stall driver: random back-pressure when enabled.
    initial forever begin
        @(negedge clk);
        stall = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
    end

    // Monitor: compares every plotted pixel and every done pulse.
    initial forever begin
        pix_t e;
        @(negedge clk);
        #1;
        if (!rst) begin
            if (stall && busy) chk("plot_low_when_stalled", int'(plot), 0);
            if (plot) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_plot", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel_x", int'(x_out), e.x);
                    chk("pixel_y", int'(y_out), e.y);
                    chk("pixel_colour", int'(colour_out), e.c);
                end
                if (!first_seen && lat_chk) chk("first_plot_latency", cyc - accept_cyc, 1);
                first_seen    = 1'b1;
                last_plot_cyc = cyc;
            end
            if (done) begin
                chk("pixels_left_at_done", exp_q.size(), 0);
                chk("busy_at_done", int'(busy), 1);
                if (exp_npix == 0) chk("empty_done_latency", cyc - accept_cyc, 1);
                else chk("done_after_last_plot", cyc - last_plot_cyc, 1);
                done_cnt++;
            end
        end
    end

    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input int colb, input int pat, input bit st_en);
        int n;
        push_expect(ax0, ay0, ax1, ay1, col, colb, pat, n);
        exp_npix   = n;
        first_seen = 1'b0;
        lat_chk    = !st_en;
        @(negedge clk);
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        colour_in = 3'(col); colour_b = 3'(colb); pattern = (pat != 0);
        start = 1'b1;
        @(negedge clk);
        accept_cyc = cyc;
        start      = 1'b0;
        stall_en   = st_en;
    endtask

    task automatic run_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int colb, input int pat,
                            input bit st_en, input bit poke);
        int d0, bound;
        d0 = done_cnt;
        issue(ax0, ay0, ax1, ay1, col, colb, pat, st_en);
        if (poke) begin
            // Starts while busy must be dropped, not queued.
            start = 1'b1; x0 = 8'($urandom); y0 = 7'($urandom);
            x1 = 8'($urandom); y1 = 7'($urandom); colour_in = 3'($urandom);
            @(negedge clk);
            @(negedge clk);
            start = 1'b0;
        end
        bound = 4 * exp_npix + 20;
        for (int k = 0; k < bound && done_cnt == d0; k++) begin
            @(negedge clk);
            #2;
        end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        stall_en = 1'b0;
        @(negedge clk);
        #1;
        chk("busy_low_after_done", int'(busy), 0);
        chk("done_single_pulse", int'(done), 0);
        chk("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        int ax0, ay0, ax1, ay1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_x_out", int'(x_out), 0);
        chk("reset_y_out", int'(y_out), 0);
        chk("reset_colour_out", int'(colour_out), 0);
        chk("reset_plot", int'(plot), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        rst = 1'b0;

        run_fill(0, 0, 159, 119, 7, 0, 0, 1'b0, 1'b0);     // full screen
        run_fill(0, 52, 159, 67, 1, 0, 0, 1'b0, 1'b0);     // band
        run_fill(150, 115, 200, 127, 5, 2, 1, 1'b0, 1'b0); // clipped corner
        run_fill(170, 10, 180, 20, 3, 0, 0, 1'b0, 1'b0);   // x0 off screen
        run_fill(10, 125, 20, 127, 3, 0, 0, 1'b0, 1'b0);   // y0 off screen
        run_fill(20, 10, 10, 20, 3, 0, 0, 1'b0, 1'b0);     // inverted x
        run_fill(10, 10, 12, 11, 6, 0, 0, 1'b1, 1'b0);     // 3x2 stalled
        run_fill(5, 5, 5, 5, 4, 0, 0, 1'b0, 1'b1);         // 1x1 with start poke
        run_fill(159, 119, 255, 127, 2, 5, 1, 1'b1, 1'b1); // last pixel only

        for (int i = 0; i < 25; i++) begin
            ax0 = $urandom_range(0, 165);
            ay0 = $urandom_range(0, 123);
            ax1 = ax0 + $urandom_range(0, 24) - 2;
            ay1 = ay0 + $urandom_range(0, 10) - 1;
            if (ax1 < 0) ax1 = 0;
            if (ax1 > 255) ax1 = 255;
            if (ay1 < 0) ay1 = 0;
            if (ay1 > 127) ay1 = 127;
            run_fill(ax0, ay0, ax1, ay1, $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a full-screen fill.
        issue(0, 0, 159, 119, 7, 0, 0, 1'b0);
        repeat (40) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_plot", int'(plot), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_done", int'(done), 0);
        chk("async_reset_x_out", int'(x_out), 0);
        chk("async_reset_y_out", int'(y_out), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_held_no_done", int'(done), 0);
        rst = 1'b0;
        run_fill(20, 30, 25, 33, 3, 4, 1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Parametrised rectangle fill engine that generalises the full-screen and band fill drawers used by the start and end screens.
- Accepts an arbitrary inclusive rectangle and a colour through a start/busy/done handshake.
- Clips the rectangle to the screen, then emits one pixel write per cycle to the VGA adapter in raster order.
- Honours a stall input, so the pixel bus can be shared through an arbiter.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- COLOUR_W, 3, width of colour
- SCREEN_W, 160, screen width in pixels; valid x is 0..SCREEN_W-1
- SCREEN_H, 120, screen height in pixels; valid y is 0..SCREEN_H-1

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a fill; sampled only in IDLE
- x0  in  X_W  left edge, inclusive
- y0  in  Y_W  top edge, inclusive
- x1  in  X_W  right edge, inclusive
- y1  in  Y_W  bottom edge, inclusive
- colour_in  in  COLOUR_W  fill colour
- stall  in  1  downstream not accepting; hold the current pixel
- x_out  out  X_W  current pixel x
- y_out  out  Y_W  current pixel y
- colour_out  out  COLOUR_W  current pixel colour
- plot  out  1  pixel write strobe; one pixel is written per cycle with plot=1
- busy  out  1  high in SETUP, FILL and DONE
- done  out  1  one-cycle pulse when the operation completes

Behaviour:
- Reset:
  - State goes to IDLE; x_out, y_out, colour_out, plot, busy and done all go to 0.
  - Reset is asynchronous: plot drops immediately, including mid-fill.
  - No done pulse is produced for an aborted fill.
- IDLE:
  - start=1 latches x0, y0, x1, y1 and colour_in, then moves to SETUP.
- SETUP (1 cycle):
  - Clip: xe = min(x1, SCREEN_W-1); ye = min(y1, SCREEN_H-1).
  - Empty if x0>xe, y0>ye, x0>=SCREEN_W or y0>=SCREEN_H.
  - Empty: go to DONE with no plot.
  - Otherwise load cx=x0, cy=y0 and go to FILL.
- FILL:
  - plot = !stall, combinational from state and stall.
  - x_out=cx, y_out=cy and colour_out=latched colour; these are driven from registers.
  - On a cycle with stall=0:
    - If cx==xe and cy==ye, go to DONE.
    - Else if cx==xe, set cx=x0 and cy=cy+1.
    - Else set cx=cx+1.
  - On a cycle with stall=1, hold cx and cy.
- DONE (1 cycle):
  - done=1, plot=0, then go to IDLE.
  - start is not accepted in this cycle.
- Latency and pixel count:
  - start accepted at cycle N gives the first plot at cycle N+2 when not stalled.
  - Total plot cycles = (xe-x0+1)*(ye-y0+1) exactly.
  - done asserts the cycle after the last plot.
- Input handling:
  - start while busy is ignored and not queued.
  - Inputs other than start are don't-care outside the IDLE accept cycle.
- Arithmetic:
  - Comparisons are unsigned.
  - The clip compares against SCREEN_W-1 and SCREEN_H-1 at full port width; counters never exceed xe or ye, so there is no wrap.
- Single-pixel rectangle (x0==x1, y0==y1): exactly one plot, then done.

Optional Feature:
- Macro: RECT_FILL_PATTERN_EN.
- When defined:
  - Adds input colour_b (COLOUR_W) and input pattern (1), both latched with start.
  - If pattern=1, colour_out = ((cx[0]^cy[0]) ? colour_b : colour) per pixel, giving a checkerboard anchored to absolute screen parity.
  - If pattern=0, output is the solid colour.
- When undefined:
  - The ports are absent and colour_out is always the latched colour_in.
  - Behaviour and timing are otherwise identical.

Test Plan:
- Full screen: start with x0=0, y0=0, x1=159, y1=119, colour=111, stall=0 -> 19200 plots in raster order; first (0,0) at N+2, last (159,119), then done=1 for one cycle and busy=0 the cycle after.
- Band: x0=0, y0=52, x1=159, y1=67, colour=001 -> 2560 plots; y_out covers 52..67; row wraps 159->0.
- Clipping: x0=150, y0=115, x1=200, y1=127 -> plots only for x 150..159 and y 115..119 (50 plots). x0=170 -> zero plots, done at N+2.
- Stall: 3x2 rectangle at (10,10) with stall=1 on 2 random cycles -> exactly 6 plots, no pixel repeated or skipped, done delayed by 2 cycles.
- start during busy, and a 1x1 rectangle at (5,5) -> the second start is ignored; 1x1 gives exactly one plot at (5,5) then done.
- Reset asserted asynchronously mid-FILL (between clock edges) -> plot, busy and done go to 0 immediately; a new start after release fills correctly.
